// File: rtl/scan_sel_ctrl.sv
// Sweep sequencer for a 2-to-4 one-hot decoder stage.
// Walks the unmasked outputs in ascending order with a dwell and a blanking gap.
module scan_sel_ctrl #(
  parameter int DWELL_W   = 8,
  parameter int BLANK_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [3:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [1:0]         sel,
  output logic               sel_en,
  output logic               busy,
  output logic               chan_strobe,
  output logic               sweep_done
);

  localparam int BW = (BLANK_CYC > 2) ? $clog2(BLANK_CYC) : 1;
  localparam logic [BW-1:0] BLK_LD =
    BW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } state_t;

  state_t             state, nstate;
  logic [DWELL_W-1:0] cnt, ncnt;
  logic [BW-1:0]      blk, nblk;
  logic [3:0]         mask_l, nmask;
  logic [DWELL_W-1:0] dwell_l, ndwell;
  logic [1:0]         nsel;
  logic               nstrobe, ndone;
  logic               eoc;
  logic               has_next;
  logic [1:0]         nxt;

  function automatic logic [1:0] low_bit(input logic [3:0] m);
    low_bit = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (m[i]) low_bit = 2'(i);
  endfunction

  // A dwell of 0 behaves as 1; the counter holds remaining cycles minus one.
  function automatic logic [DWELL_W-1:0] ld(input logic [DWELL_W-1:0] d);
    ld = (d == '0) ? '0 : d - 1'b1;
  endfunction

  // Next unmasked channel above the current one within this sweep.
  always_comb begin
    has_next = 1'b0;
    nxt      = sel;
    for (int i = 3; i >= 0; i--) begin
      if (mask_l[i] && (i > int'(sel))) begin
        has_next = 1'b1;
        nxt      = 2'(i);
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    nstate  = state;
    nsel    = sel;
    ncnt    = cnt;
    nblk    = blk;
    nmask   = mask_l;
    ndwell  = dwell_l;
    nstrobe = 1'b0;
    ndone   = 1'b0;
    eoc     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop && (mask != 4'd0)) begin
          nstate  = ACTIVE;
          nsel    = low_bit(mask);
          nmask   = mask;
          ndwell  = dwell;
          ncnt    = ld(dwell);
          nstrobe = 1'b1;
        end
      end
      ACTIVE: begin
        if (stop) begin
          nstate = IDLE;
        end else if (cnt != '0) begin
          ncnt = cnt - 1'b1;
        end else if (BLANK_CYC > 0) begin
          nstate = BLANK;
          nblk   = BLK_LD;
        end else begin
          eoc = 1'b1;
        end
      end
      BLANK: begin
        if (stop) begin
          nstate = IDLE;
        end else if (blk != '0) begin
          nblk = blk - 1'b1;
        end else begin
          eoc = 1'b1;
        end
      end
      default: nstate = IDLE;
    endcase
    if (eoc) begin
      if (has_next) begin
        nstate  = ACTIVE;
        nsel    = nxt;
        ncnt    = ld(dwell_l);
        nstrobe = 1'b1;
      end else begin
        ndone = 1'b1;
        if (cont && (mask != 4'd0)) begin
          nstate  = ACTIVE;
          nsel    = low_bit(mask);
          nmask   = mask;
          ndwell  = dwell;
          ncnt    = ld(dwell);
          nstrobe = 1'b1;
        end else begin
          nstate = IDLE;
        end
      end
    end
  end

  // State, latches and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      blk         <= '0;
      mask_l      <= '0;
      dwell_l     <= '0;
      sel         <= 2'd0;
      sel_en      <= 1'b0;
      busy        <= 1'b0;
      chan_strobe <= 1'b0;
      sweep_done  <= 1'b0;
    end else begin
      state       <= nstate;
      cnt         <= ncnt;
      blk         <= nblk;
      mask_l      <= nmask;
      dwell_l     <= ndwell;
      sel         <= nsel;
      sel_en      <= (nstate == ACTIVE);
      busy        <= (nstate != IDLE);
      chan_strobe <= nstrobe;
      sweep_done  <= ndone;
    end
  end

endmodule

// File: tb/tb_scan_sel_ctrl.sv
// Directed bench for scan_sel_ctrl.
// u0 uses a 2-cycle blanking gap, u1 has no gap.
module tb_scan_sel_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop, cont;
  logic [3:0] mask;
  logic [7:0] dwell;

  logic [1:0] sel0, sel1;
  logic       en0, en1, busy0, busy1;
  logic       str0, str1, done0, done1;

  int checks = 0;
  int errors = 0;

  // {sel, sel_en, busy, chan_strobe, sweep_done}
  wire [5:0] obs0 = {sel0, en0, busy0, str0, done0};
  wire [5:0] obs1 = {sel1, en1, busy1, str1, done1};

  always #5 clk = ~clk;

  scan_sel_ctrl #(.DWELL_W(8), .BLANK_CYC(2)) u0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cont(cont), .mask(mask), .dwell(dwell),
    .sel(sel0), .sel_en(en0), .busy(busy0),
    .chan_strobe(str0), .sweep_done(done0)
  );

  scan_sel_ctrl #(.DWELL_W(8), .BLANK_CYC(0)) u1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cont(cont), .mask(mask), .dwell(dwell),
    .sel(sel1), .sel_en(en1), .busy(busy1),
    .chan_strobe(str1), .sweep_done(done1)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    cont = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0;
    mask = 4'b0000; dwell = 8'd0;
    cyc();
    cyc();
    checks++;
    if (obs0 !== 6'b00_0000) begin
      errors++;
      $display("FAIL reset_u0 got %b want %b", obs0, 6'b00_0000);
    end
    checks++;
    if (obs1 !== 6'b00_0000) begin
      errors++;
      $display("FAIL reset_u1 got %b want %b", obs1, 6'b00_0000);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_single_sweep();
    logic [5:0] exp;
    logic [1:0] es;
    do_reset();
    mask = 4'b0101; dwell = 8'd3;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      es  = (k < 6) ? 2'd0 : 2'd2;
      exp = {es,
             ((k >= 1 && k <= 3) || (k >= 6 && k <= 8)),
             (k <= 10),
             (k == 1 || k == 6),
             (k == 11)};
      checks++;
      if (obs0 !== exp) begin
        errors++;
        $display("FAIL single_c%0d got %b want %b", k, obs0, exp);
      end
      cyc();
    end
  endtask

  task automatic test_continuous();
    logic [5:0] exp;
    int p;
    do_reset();
    cont = 1'b1; mask = 4'b1111; dwell = 8'd1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      p = (k - 1) % 12;
      if (k == 25)
        exp = {2'd3, 1'b0, 1'b0, 1'b0, 1'b1};
      else if (k == 26)
        exp = {2'd3, 1'b0, 1'b0, 1'b0, 1'b0};
      else
        exp = {2'(p / 3), (p % 3 == 0), 1'b1,
               (p % 3 == 0), (k == 13)};
      checks++;
      if (obs0 !== exp) begin
        errors++;
        $display("FAIL cont_c%0d got %b want %b", k, obs0, exp);
      end
      if (k == 13) mask = 4'b0000;
      cyc();
    end
    cont = 1'b0;
  endtask

  task automatic test_no_gap();
    logic [5:0] exp [1:4];
    exp[1] = {2'd0, 4'b1110};
    exp[2] = {2'd3, 4'b1110};
    exp[3] = {2'd3, 4'b0001};
    exp[4] = {2'd3, 4'b0000};
    do_reset();
    mask = 4'b1001; dwell = 8'd0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (obs1 !== exp[k]) begin
        errors++;
        $display("FAIL nogap_c%0d got %b want %b", k, obs1, exp[k]);
      end
      cyc();
    end
  endtask

  task automatic test_stop();
    logic [5:0] exp;
    do_reset();
    mask = 4'b0110; dwell = 8'd3;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k == 1) exp = {2'd1, 4'b1110};
      else if (k == 2) exp = {2'd1, 4'b1100};
      else exp = {2'd1, 4'b0000};
      checks++;
      if (obs0 !== exp) begin
        errors++;
        $display("FAIL stop_c%0d got %b want %b", k, obs0, exp);
      end
      stop = (k == 2);
      cyc();
    end
    mask = 4'b1100;
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if (obs0 !== {2'd2, 4'b1110}) begin
      errors++;
      $display("FAIL stop_restart got %b want %b", obs0, {2'd2, 4'b1110});
    end
  endtask

  task automatic test_abort_ignore();
    do_reset();
    mask = 4'b0001; dwell = 8'd1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    checks++;
    if (obs0 !== {2'd0, 4'b0100}) begin
      errors++;
      $display("FAIL abort_blank got %b want %b", obs0, {2'd0, 4'b0100});
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs0 !== 6'b00_0000) begin
        errors++;
        $display("FAIL abort_rst%0d got %b want %b", k, obs0, 6'b0);
      end
      cyc();
    end
    mask = 4'b1000;
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    checks++;
    if (obs0 !== 6'b00_0000) begin
      errors++;
      $display("FAIL start_stop got %b want %b", obs0, 6'b0);
    end
    mask = 4'b0000;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs0 !== 6'b00_0000) begin
        errors++;
        $display("FAIL mask0_c%0d got %b want %b", k, obs0, 6'b0);
      end
      cyc();
    end
  endtask

  task automatic test_relatch();
    logic [5:0] exp [1:13];
    exp[1]  = 6'b00_1110;
    exp[2]  = 6'b00_1100;
    exp[3]  = 6'b00_0100;
    exp[4]  = 6'b00_0100;
    exp[5]  = 6'b01_1110;
    exp[6]  = 6'b01_1100;
    exp[7]  = 6'b01_0100;
    exp[8]  = 6'b01_0100;
    exp[9]  = 6'b10_1111;
    exp[10] = 6'b10_0100;
    exp[11] = 6'b10_0100;
    exp[12] = 6'b10_1111;
    exp[13] = 6'b10_0000;
    do_reset();
    cont = 1'b1; mask = 4'b0011; dwell = 8'd2;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      checks++;
      if (obs0 !== exp[k]) begin
        errors++;
        $display("FAIL relatch_c%0d got %b want %b", k, obs0, exp[k]);
      end
      if (k == 2) begin
        mask = 4'b0100;
        dwell = 8'd1;
      end
      stop = (k == 12);
      cyc();
    end
    cont = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_sweep();
    test_continuous();
    test_no_gap();
    test_stop();
    test_abort_ignore();
    test_relatch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
